// File: rtl/neo_pbus_pkg.sv
// Shared types and helpers for the PBUS fetch block: FSM states, slice rotation
// and the channel-index width.
package neo_pbus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

    function automatic int ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Rotate-left of pbus[src_w-1:0] by rot within src_w bits; upper bits are zero.
    function automatic logic [31:0] pbus_rot(input logic [31:0] pbus, input int src_w, input int rot);
        logic [31:0] r;
        int unsigned k;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < src_w) begin
                k = int'(unsigned'(i + rot)) % int'(unsigned'(src_w));
                r[k[4:0]] = pbus[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/neo_pbus_fetch_if.sv
// PBUS capture / SDRAM beat-request bundle. master drives strobes and acks,
// slave is the fetch block.
interface neo_pbus_fetch_if
    import neo_pbus_pkg::*;
#(
    parameter int PBUS_W = 20,
    parameter int NCH    = 2,
    parameter int ADDR_W = 20
);
    localparam int CH_W = ch_w(NCH);

    logic [PBUS_W-1:0]     pbus;
    logic [NCH-1:0]        stb_en;
    logic                  clr_ovr;
    logic [NCH*ADDR_W-1:0] latch;
    logic [NCH-1:0]        busy;
    logic [NCH-1:0]        overrun;
    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic [CH_W-1:0]       mem_ch;
    logic                  mem_ack;

    modport master (
        output pbus, stb_en, clr_ovr, mem_ack,
        input  latch, busy, overrun, mem_req, mem_addr, mem_ch
    );

    modport slave (
        input  pbus, stb_en, clr_ovr, mem_ack,
        output latch, busy, overrun, mem_req, mem_addr, mem_ch
    );

endinterface

// File: rtl/neo_pbus_chan.sv
// One capture channel: rotated PBUS slice latch, pending-fetch flag and sticky
// overrun flag.
module neo_pbus_chan
    import neo_pbus_pkg::*;
#(
    parameter int PBUS_W = 20,
    parameter int ADDR_W = 20,
    parameter int SRC_W  = 20,
    parameter int ROT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PBUS_W-1:0] pbus,
    input  logic              stb,
    input  logic              grant,
    input  logic              clr_ovr,
    output logic [ADDR_W-1:0] latch,
    output logic              pending,
    output logic              overrun
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch   <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (stb) begin
                latch <= ADDR_W'(pbus_rot(32'(pbus), SRC_W, ROT));
            end
            // A strobe in the grant cycle re-arms the channel instead of losing it.
            if (stb) begin
                pending <= 1'b1;
            end else if (grant) begin
                pending <= 1'b0;
            end
            if (stb && pending && !grant) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/neo_pbus_fetch.sv
// Multi-channel PBUS address latch with fixed-priority burst fetch issue to the
// SDRAM controller. Lowest pending channel index wins.
module neo_pbus_fetch
    import neo_pbus_pkg::*;
#(
    parameter int               PBUS_W = 20,
    parameter int               NCH    = 2,
    parameter int               ADDR_W = 20,
    parameter logic [NCH*5-1:0] SRC_W  = {5'd16, 5'd20},
    parameter logic [NCH*5-1:0] ROT    = {5'd4, 5'd4},
    parameter int               BURST  = 4,
    parameter int               STEP   = 1
) (
    input  logic            clk,
    input  logic            rst,
    neo_pbus_fetch_if.slave bus
);

    localparam int CH_W   = ch_w(NCH);
    localparam int BEAT_W = 5;

    fetch_state_t          state;
    logic [BEAT_W-1:0]     beat;
    logic                  mem_req_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [CH_W-1:0]       mem_ch_q;

    logic [NCH*ADDR_W-1:0] latch_flat;
    logic [NCH-1:0]        pending;
    logic [NCH-1:0]        overrun;
    logic [NCH-1:0]        grant;
    logic [NCH-1:0]        busy;
    logic                  gnt_any;
    logic [CH_W-1:0]       gnt_idx;
    logic [ADDR_W-1:0]     gnt_base;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        neo_pbus_chan #(
            .PBUS_W (PBUS_W),
            .ADDR_W (ADDR_W),
            .SRC_W  (int'(SRC_W[i*5 +: 5])),
            .ROT    (int'(ROT[i*5 +: 5]))
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .pbus    (bus.pbus),
            .stb     (bus.stb_en[i]),
            .grant   (grant[i]),
            .clr_ovr (bus.clr_ovr),
            .latch   (latch_flat[i*ADDR_W +: ADDR_W]),
            .pending (pending[i]),
            .overrun (overrun[i])
        );
    end

    // Scan from the top so the lowest pending index is the last one written.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_base = '0;
        grant    = '0;
        if (state == IDLE) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (pending[i]) begin
                    gnt_any  = 1'b1;
                    gnt_idx  = CH_W'(i);
                    gnt_base = latch_flat[i*ADDR_W +: ADDR_W];
                    grant    = '0;
                    grant[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy = pending;
        for (int i = 0; i < NCH; i++) begin
            if (state == REQ && mem_ch_q == CH_W'(i)) begin
                busy[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_ch_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        state      <= REQ;
                        beat       <= '0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= gnt_base;
                        mem_ch_q   <= gnt_idx;
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        if (beat == BEAT_W'(BURST - 1)) begin
                            mem_req_q <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            beat       <= beat + BEAT_W'(1);
                            mem_addr_q <= mem_addr_q + ADDR_W'(STEP);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.latch    = latch_flat;
    assign bus.busy     = busy;
    assign bus.overrun  = overrun;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_ch   = mem_ch_q;

endmodule

// File: tb/tb_neo_pbus_fetch.sv
// Bench for neo_pbus_fetch: directed cases plus random strobes/acks against a
// transaction-level model; expected beats go through a scoreboard queue.
module tb_neo_pbus_fetch;

    localparam int PBUS_W = 20;
    localparam int NCH    = 2;
    localparam int ADDR_W = 20;
    localparam int BURST  = 4;
    localparam int STEP   = 1;

    typedef struct {
        int          ch;
        logic [19:0] addr;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_drain;

    always #5 clk = ~clk;

    neo_pbus_fetch_if #(.PBUS_W(PBUS_W), .NCH(NCH), .ADDR_W(ADDR_W)) bus ();

    neo_pbus_fetch #(
        .PBUS_W (PBUS_W),
        .NCH    (NCH),
        .ADDR_W (ADDR_W),
        .SRC_W  ({5'd16, 5'd20}),
        .ROT    ({5'd4, 5'd4}),
        .BURST  (BURST),
        .STEP   (STEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state
    int          src_w_m [2] = '{20, 16};
    int          rot_m   [2] = '{4, 4};
    logic [19:0] m_latch [2];
    bit          m_pend  [2];
    bit          m_ovr   [2];
    bit          m_req;
    int          m_ch;
    int          m_left;
    beat_t       exp_q[$];

    function automatic logic [19:0] model_rot(input logic [19:0] p, input int w, input int r);
        longint unsigned mask, x;
        int rr;
        mask = (64'd1 << w) - 1;
        x    = longint'(p) & mask;
        rr   = r % w;
        return 20'(((x << rr) | (x >> (w - rr))) & mask);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_latch[i] = '0;
                m_pend[i]  = 1'b0;
                m_ovr[i]   = 1'b0;
            end
            m_req  = 1'b0;
            m_ch   = 0;
            m_left = 0;
            exp_q.delete();
        end else begin
            int g;
            beat_t b;
            g = -1;
            if (!m_req) begin
                for (int i = 0; i < 2; i++)
                    if (m_pend[i] && g < 0) g = i;
            end
            if (g >= 0) begin
                for (int k = 0; k < BURST; k++) begin
                    b.ch   = g;
                    b.addr = 20'(int'(m_latch[g]) + k * STEP);
                    exp_q.push_back(b);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (bus.stb_en[i] && m_pend[i] && g != i) m_ovr[i] = 1'b1;
                else if (bus.clr_ovr) m_ovr[i] = 1'b0;
                if (bus.stb_en[i]) begin
                    m_latch[i] = model_rot(bus.pbus, src_w_m[i], rot_m[i]);
                    m_pend[i]  = 1'b1;
                end else if (g == i) begin
                    m_pend[i] = 1'b0;
                end
            end
            if (g >= 0) begin
                m_req  = 1'b1;
                m_ch   = g;
                m_left = BURST;
            end else if (m_req && bus.mem_ack) begin
                m_left--;
                if (m_left == 0) m_req = 1'b0;
            end
        end
    end

    // Monitor: state comparison every cycle, beat scoreboard on each handshake.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("mem_req", 32'(bus.mem_req), 32'(m_req));
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("latch%0d", i), 32'(bus.latch[i*ADDR_W +: ADDR_W]), 32'(m_latch[i]));
                chk($sformatf("busy%0d", i), 32'(bus.busy[i]), 32'(m_pend[i] || (m_req && m_ch == i)));
                chk($sformatf("overrun%0d", i), 32'(bus.overrun[i]), 32'(m_ovr[i]));
            end
            if (bus.mem_req && bus.mem_ack) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_ch", 32'(bus.mem_ch), 32'(e.ch));
                    chk("beat_addr", 32'(bus.mem_addr), 32'(e.addr));
                end
            end
        end
    end

    task automatic tick(input logic [19:0] p, input logic [1:0] s, input logic a, input logic c);
        bus.pbus    = p;
        bus.stb_en  = s;
        bus.mem_ack = a;
        bus.clr_ovr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic a);
        for (int i = 0; i < n; i++) tick(20'h0, 2'b00, a, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.pbus    = '0;
        bus.stb_en  = '0;
        bus.mem_ack = 1'b1;
        bus.clr_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_ch", 32'(bus.mem_ch), 32'd0);
        chk("rst_latch", 32'(bus.latch), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        rst = 1'b0;
        idle(2, 1'b1);

        // Channel 0 capture and burst
        tick(20'hABCDE, 2'b01, 1'b1, 1'b0);
        chk("latch0_abcde", 32'(bus.latch[19:0]), 32'h000BCDEA);
        idle(8, 1'b1);
        chk("busy_after_ch0", 32'(bus.busy), 32'd0);

        // Channel 1 capture and burst
        tick(20'h01234, 2'b10, 1'b1, 1'b0);
        chk("latch1_01234", 32'(bus.latch[39:20]), 32'h00002341);
        idle(8, 1'b1);

        // Simultaneous strobes
        tick(20'h5A5A5, 2'b11, 1'b1, 1'b0);
        idle(14, 1'b1);
        chk("simul_overrun", 32'(bus.overrun), 32'd0);

        // Overrun with stalled acks
        tick(20'h11111, 2'b01, 1'b0, 1'b0);
        idle(2, 1'b0);
        tick(20'h22222, 2'b01, 1'b0, 1'b0);
        idle(1, 1'b0);
        tick(20'h12345, 2'b01, 1'b0, 1'b0);
        chk("ovr_set", 32'(bus.overrun[0]), 32'd1);
        chk("ovr_latch", 32'(bus.latch[19:0]), 32'h00023451);
        tick(20'h0, 2'b00, 1'b0, 1'b1);
        chk("ovr_clr", 32'(bus.overrun[0]), 32'd0);
        idle(14, 1'b1);

        // Address wrap
        tick(20'hEFFFF, 2'b01, 1'b1, 1'b0);
        chk("latch0_wrap", 32'(bus.latch[19:0]), 32'h000FFFFE);
        idle(8, 1'b1);

        // Reset in the middle of a burst
        tick(20'h13579, 2'b01, 1'b0, 1'b0);
        idle(3, 1'b1);
        bus.mem_ack = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_req", 32'(bus.mem_req), 32'd0);
        chk("midrst_latch", 32'(bus.latch), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5, 1'b1);
        chk("post_rst_req", 32'(bus.mem_req), 32'd0);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            logic [1:0] s;
            s[0] = ($urandom_range(0, 7) == 0);
            s[1] = ($urandom_range(0, 7) == 0);
            tick(20'($urandom()), s, ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
        end

        n_drain = 0;
        while ((m_req || m_pend[0] || m_pend[1]) && n_drain < 300) begin
            tick(20'h0, 2'b00, 1'b1, 1'b0);
            n_drain++;
        end
        chk("drain_bound", 32'(n_drain < 300), 32'd1);
        idle(2, 1'b1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
